// File: rtl/game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg : shared state encoding and round-length default for game_ctrl
// Rev 1.0
// ============================================================================
package game_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_START  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam int GAME_SECS_DEF = 60;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD   = ST_LOAD,
    S_START  = ST_START,
    S_FINISH = ST_FINISH
  } state_e;

endpackage
`default_nettype wire

// File: rtl/game_ctrl_if.sv
`default_nettype none
// ============================================================================
// game_ctrl_if : player/mole inputs and sequencer outputs of game_ctrl
// Rev 1.0
// ============================================================================
interface game_ctrl_if #(
  parameter int NUM_HOLES = 9
);

  logic                 start_btn;
  logic                 sec_tick;
  logic [NUM_HOLES-1:0] hit;
  logic [NUM_HOLES-1:0] mole_up;
  logic [1:0]           global_state;
  logic                 score_clear;
  logic                 score_trigger;
  logic [NUM_HOLES-1:0] mole_clear;
  logic [7:0]           time_left;

  modport master (
    output start_btn, sec_tick, hit, mole_up,
    input  global_state, score_clear, score_trigger, mole_clear, time_left
  );

  modport slave (
    input  start_btn, sec_tick, hit, mole_up,
    output global_state, score_clear, score_trigger, mole_clear, time_left
  );

endinterface
`default_nettype wire

// File: rtl/game_ctrl_hit_popcount.sv
`default_nettype none
// ============================================================================
// hit_popcount : combinational count of set bits in the valid-hit vector
// Rev 1.0
// ============================================================================
module hit_popcount #(
  parameter int NUM_HOLES = 9,
  parameter int CNT_W     = $clog2(NUM_HOLES + 1)
) (
  input  logic [NUM_HOLES-1:0] vec,
  output logic [CNT_W-1:0]     count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      count = count + CNT_W'(vec[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// game_ctrl : whack-a-mole sequencer - round FSM, hit validation/serialising,
//             round timer
// Rev 1.0
// ============================================================================
module game_ctrl
  import game_pkg::*;
#(
  parameter int NUM_HOLES   = 9,
  parameter int GAME_SECS   = GAME_SECS_DEF,
  parameter int LOAD_CYCLES = 16,
  parameter int PEND_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  game_ctrl_if.slave  bus
);

  localparam int CNT_W  = $clog2(NUM_HOLES + 1);
  localparam int SUM_W  = PEND_W + CNT_W;
  localparam int LCNT_W = $clog2(LOAD_CYCLES + 1);

  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [LCNT_W-1:0] LOAD_LAST = LCNT_W'(LOAD_CYCLES - 1);
  localparam logic [7:0]        SECS_INIT = 8'(GAME_SECS);

  state_e               state_q, state_d;
  logic [LCNT_W-1:0]    load_cnt_q, load_cnt_d;
  logic [7:0]           time_left_q, time_left_d;
  logic [PEND_W-1:0]    pending_q, pending_d;
  logic                 score_trigger_q, score_trigger_d;
  logic                 score_clear_q, score_clear_d;
  logic [NUM_HOLES-1:0] mole_clear_q, mole_clear_d;

  logic [NUM_HOLES-1:0] valid;
  logic [CNT_W-1:0]     valid_cnt;
  logic [SUM_W-1:0]     total;
  logic [SUM_W-1:0]     drained;

  assign valid = (state_q == S_START) ? (bus.hit & bus.mole_up) : '0;

  hit_popcount #(
    .NUM_HOLES (NUM_HOLES),
    .CNT_W     (CNT_W)
  ) u_hit_popcount (
    .vec   (valid),
    .count (valid_cnt)
  );

  always_comb begin
    state_d         = state_q;
    load_cnt_d      = load_cnt_q;
    time_left_d     = time_left_q;
    pending_d       = pending_q;
    score_trigger_d = 1'b0;
    total           = SUM_W'(pending_q) + SUM_W'(valid_cnt);
    drained         = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_btn) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (load_cnt_q == LOAD_LAST) state_d = S_START;
        else                         load_cnt_d = load_cnt_q + 1'b1;
      end
      S_START: begin
        if (bus.sec_tick) begin
          if (time_left_q > 8'd1) begin
            time_left_d = time_left_q - 8'd1;
          end else begin
            time_left_d = '0;
            state_d     = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        if (bus.start_btn) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_LOAD) && (state_q != S_LOAD)) begin
      load_cnt_d  = '0;
      time_left_d = SECS_INIT;
    end

    // Entering or sitting in LOAD flushes the backlog so no point is
    // scored while the counter is being cleared.
    if (state_d == S_LOAD) begin
      pending_d       = '0;
      score_trigger_d = 1'b0;
    end else begin
      score_trigger_d = (total != '0);
      drained         = total - SUM_W'(score_trigger_d);
      pending_d       = (drained > SUM_W'(PEND_MAX)) ? PEND_MAX : drained[PEND_W-1:0];
    end

    mole_clear_d  = valid;
    score_clear_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      load_cnt_q      <= '0;
      time_left_q     <= '0;
      pending_q       <= '0;
      score_trigger_q <= 1'b0;
      score_clear_q   <= 1'b0;
      mole_clear_q    <= '0;
    end else begin
      state_q         <= state_d;
      load_cnt_q      <= load_cnt_d;
      time_left_q     <= time_left_d;
      pending_q       <= pending_d;
      score_trigger_q <= score_trigger_d;
      score_clear_q   <= score_clear_d;
      mole_clear_q    <= mole_clear_d;
    end
  end

  assign bus.global_state  = state_q;
  assign bus.score_clear   = score_clear_q;
  assign bus.score_trigger = score_trigger_q;
  assign bus.mole_clear    = mole_clear_q;
  assign bus.time_left     = time_left_q;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// tb_game_ctrl : directed + random stimulus, per-cycle scoreboard against a
//                rule-level model of the game sequencer
// Rev 1.0
// ============================================================================
module tb_game_ctrl;

  localparam int NH     = 9;
  localparam int SECS   = 60;
  localparam int LOADC  = 16;
  localparam int PMAX   = 15;

  typedef struct {
    logic [1:0]    st;
    logic          sc;
    logic          trig;
    logic [NH-1:0] mc;
    logic [7:0]    tl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_ctrl_if #(.NUM_HOLES(NH)) bus ();

  game_ctrl #(
    .NUM_HOLES   (NH),
    .GAME_SECS   (SECS),
    .LOAD_CYCLES (LOADC),
    .PEND_W      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: game phase, queued points, seconds left, LOAD cycles left.
  int m_phase = 0;
  int m_pend  = 0;
  int m_secs  = 0;
  int m_load  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endfunction

  task automatic model_step(input logic r, input logic s, input logic t,
                            input logic [NH-1:0] h, input logic [NH-1:0] m,
                            output exp_t e);
    logic [NH-1:0] v;
    int            total;
    bit            trig;
    v    = '0;
    trig = 1'b0;
    if (r) begin
      m_phase = 0; m_pend = 0; m_secs = 0; m_load = 0;
      e.st = 2'd0; e.sc = 1'b0; e.trig = 1'b0; e.mc = '0; e.tl = 8'd0;
      return;
    end
    case (m_phase)
      0: if (s) begin m_phase = 1; m_load = LOADC; m_secs = SECS; end
      1: begin
        m_load = m_load - 1;
        if (m_load == 0) m_phase = 2;
      end
      2: begin
        v = h & m;
        if (t) begin
          if (m_secs > 1) m_secs = m_secs - 1;
          else begin m_secs = 0; m_phase = 3; end
        end
      end
      default: if (s) begin m_phase = 1; m_load = LOADC; m_secs = SECS; end
    endcase
    if (m_phase == 1) begin
      m_pend = 0;
    end else begin
      total  = m_pend + $countones(v);
      trig   = (total > 0);
      m_pend = total - (trig ? 1 : 0);
      if (m_pend > PMAX) m_pend = PMAX;
    end
    e.st = 2'(m_phase); e.sc = (m_phase == 1); e.trig = trig; e.mc = v; e.tl = 8'(m_secs);
  endtask

  task automatic step(input logic r, input logic s, input logic t,
                      input logic [NH-1:0] h, input logic [NH-1:0] m);
    exp_t e;
    rst           = r;
    bus.start_btn = s;
    bus.sec_tick  = t;
    bus.hit       = h;
    bus.mole_up   = m;
    model_step(r, s, t, h, m, e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n, input logic [NH-1:0] m);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, m);
  endtask

  // A full round that ends on a sec_tick carrying hit vector h.
  task automatic run_to_timeout(input logic [NH-1:0] h);
    for (int i = 0; i < SECS - 1; i++) begin
      step(1'b0, 1'b0, 1'b1, '0, '0);
      step(1'b0, 1'b0, 1'b0, '0, '0);
    end
    step(1'b0, 1'b0, 1'b1, h, h);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("global_state",  32'(bus.global_state),  32'(e.st));
      check("score_clear",   32'(bus.score_clear),   32'(e.sc));
      check("score_trigger", 32'(bus.score_trigger), 32'(e.trig));
      check("mole_clear",    32'(bus.mole_clear),    32'(e.mc));
      check("time_left",     32'(bus.time_left),     32'(e.tl));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic          r, s, t;
    logic [NH-1:0] h, m;
    bus.start_btn = 1'b0;
    bus.sec_tick  = 1'b0;
    bus.hit       = '0;
    bus.mole_up   = '0;
    @(posedge clk);
    #1;

    // Reset and the LOAD window
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    idle(2, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 9'h1FF, 9'h1FF);   // start/tick/hits inside LOAD
    idle(LOADC, '0);

    // Single hit, masked burst, saturating double burst
    step(1'b0, 1'b0, 1'b0, 9'h004, 9'h004);
    idle(3, 9'h004);
    step(1'b0, 1'b0, 1'b0, 9'h1F1, 9'h0F0);
    idle(6, 9'h0F0);
    step(1'b0, 1'b0, 1'b0, 9'h1FF, 9'h1FF);
    step(1'b0, 1'b1, 1'b0, 9'h1FF, 9'h1FF);   // start_btn ignored in START
    idle(20, '0);

    // Timeout with a hit on the last tick, then hits in FINISH
    run_to_timeout(9'h010);
    idle(3, '0);
    step(1'b0, 1'b0, 1'b1, 9'h1FF, 9'h1FF);
    idle(3, '0);

    // Restart; timeout with 4 hits leaves 3 queued, restart flushes them
    step(1'b0, 1'b1, 1'b0, '0, '0);
    idle(LOADC, '0);
    run_to_timeout(9'h00F);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    idle(LOADC + 2, '0);

    // Reset in the middle of a burst
    step(1'b0, 1'b0, 1'b0, 9'h1FF, 9'h1FF);
    step(1'b1, 1'b0, 1'b0, 9'h1FF, 9'h1FF);
    idle(4, '0);

    // Randomised play
    for (int i = 0; i < 2500; i++) begin
      r = ($urandom_range(0, 599) == 0);
      s = ($urandom_range(0, 29) == 0);
      t = ($urandom_range(0, 3) == 0);
      m = NH'($urandom);
      h = NH'($urandom) & NH'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        m = '1;
        h = '1;
      end
      step(r, s, t, h, m);
    end
    idle(20, '0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
